// File: rtl/beta_regfile_mp_if.sv
// Port bundle between decode/writeback (master) and the multi-port register file (slave).
// Signal names keep the register file's point of view (_i into it, _o out of it).
interface beta_regfile_mp_if #(
  parameter int DataWidth     = 32,
  parameter int NumRegs       = 32,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 1
);
  localparam int AddrWidth = $clog2(NumRegs);

  logic [NumReadPorts-1:0][AddrWidth-1:0]  rf_raddr_i;
  logic [NumReadPorts-1:0][DataWidth-1:0]  rf_rdata_o;
  logic [NumReadPorts-1:0]                 rf_rbusy_o;
  logic [NumWritePorts-1:0]                rf_we_i;
  logic [NumWritePorts-1:0][AddrWidth-1:0] rf_waddr_i;
  logic [NumWritePorts-1:0][DataWidth-1:0] rf_wdata_i;
  logic                                    rf_set_busy_i;
  logic [AddrWidth-1:0]                    rf_set_addr_i;
  logic                                    rf_flush_i;

  modport master (
    output rf_raddr_i,
    input  rf_rdata_o,
    input  rf_rbusy_o,
    output rf_we_i,
    output rf_waddr_i,
    output rf_wdata_i,
    output rf_set_busy_i,
    output rf_set_addr_i,
    output rf_flush_i
  );

  modport slave (
    input  rf_raddr_i,
    output rf_rdata_o,
    output rf_rbusy_o,
    input  rf_we_i,
    input  rf_waddr_i,
    input  rf_wdata_i,
    input  rf_set_busy_i,
    input  rf_set_addr_i,
    input  rf_flush_i
  );
endinterface

// File: rtl/beta_regfile_mp.sv
// Multi-port register file with busy-bit scoreboard; reads are 0-cycle, writes land next edge.
// Optional write-to-read forwarding when BETA_RF_BYPASS_EN is defined. No backpressure.
module beta_regfile_mp #(
  parameter int DataWidth     = 32,
  parameter int NumRegs       = 32,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  beta_regfile_mp_if.slave  rf_if
);
  localparam int AddrWidth = $clog2(NumRegs);

  logic [DataWidth-1:0] r_regs [NumRegs];
  logic [NumRegs-1:0]   r_busy;

  logic [NumRegs-1:0]   w_wr_en;
  logic [DataWidth-1:0] w_wr_dat [NumRegs];
  logic [NumRegs-1:0]   w_set;
  logic [NumRegs-1:0]   w_busy_nxt;

  // Ascending port loop: the highest-index writer to an address overrides lower ones.
  always_comb begin
    w_wr_en = '0;
    for (int r = 0; r < NumRegs; r++) begin
      w_wr_dat[r] = '0;
    end
    for (int p = 0; p < NumWritePorts; p++) begin
      if (rf_if.rf_we_i[p] && (rf_if.rf_waddr_i[p] != '0)) begin
        w_wr_en[rf_if.rf_waddr_i[p]]  = 1'b1;
        w_wr_dat[rf_if.rf_waddr_i[p]] = rf_if.rf_wdata_i[p];
      end
    end
  end

  always_comb begin
    w_set = '0;
    if (rf_if.rf_set_busy_i && (rf_if.rf_set_addr_i != '0)) begin
      w_set[rf_if.rf_set_addr_i] = 1'b1;
    end
  end

  // A new producer (set) outranks a retiring one (write); flush outranks both.
  always_comb begin
    if (rf_if.rf_flush_i) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = (r_busy & ~w_wr_en) | w_set;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < NumRegs; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 1; r < NumRegs; r++) begin
        if (w_wr_en[r]) begin
          r_regs[r] <= w_wr_dat[r];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      rf_if.rf_rdata_o[p] = r_regs[rf_if.rf_raddr_i[p]];
      rf_if.rf_rbusy_o[p] = r_busy[rf_if.rf_raddr_i[p]];
`ifdef BETA_RF_BYPASS_EN
      if (w_wr_en[rf_if.rf_raddr_i[p]]) begin
        rf_if.rf_rdata_o[p] = w_wr_dat[rf_if.rf_raddr_i[p]];
        rf_if.rf_rbusy_o[p] = w_set[rf_if.rf_raddr_i[p]];
      end
`endif
    end
  end

endmodule

// File: tb/tb_beta_regfile_mp.sv
// Directed bench for beta_regfile_mp: a 32x32 2R/2W instance for function and scoreboard,
// plus a 16x64 4R/2W instance for the parameter sweep.
module tb_beta_regfile_mp;
  logic clk_i;
  logic rstn_i;

  int n_checks;
  int n_fail;

  beta_regfile_mp_if #(.DataWidth(32), .NumRegs(32), .NumReadPorts(2), .NumWritePorts(2)) if_a ();
  beta_regfile_mp_if #(.DataWidth(64), .NumRegs(16), .NumReadPorts(4), .NumWritePorts(2)) if_b ();

  beta_regfile_mp #(.DataWidth(32), .NumRegs(32), .NumReadPorts(2), .NumWritePorts(2)) u_dut_a (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .rf_if  (if_a.slave)
  );

  beta_regfile_mp #(.DataWidth(64), .NumRegs(16), .NumReadPorts(4), .NumWritePorts(2)) u_dut_b (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .rf_if  (if_b.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_a();
    if_a.rf_we_i       = '0;
    if_a.rf_waddr_i    = '0;
    if_a.rf_wdata_i    = '0;
    if_a.rf_set_busy_i = 1'b0;
    if_a.rf_set_addr_i = '0;
    if_a.rf_flush_i    = 1'b0;
  endtask

  function automatic logic [63:0] sweep_val(input int r);
    return 64'hF00D_0000_0000_0000 + 64'(r) * 64'h0001_0001_0001_0001;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn_i   = 1'b0;
    idle_a();
    if_a.rf_raddr_i    = '0;
    if_b.rf_raddr_i    = '0;
    if_b.rf_we_i       = '0;
    if_b.rf_waddr_i    = '0;
    if_b.rf_wdata_i    = '0;
    if_b.rf_set_busy_i = 1'b0;
    if_b.rf_set_addr_i = '0;
    if_b.rf_flush_i    = 1'b0;

    // Reset state
    repeat (3) step();
    if_a.rf_raddr_i[0] = 5'd5;
    if_a.rf_raddr_i[1] = 5'd31;
    #1;
    chk("rst_rdata0", 64'(if_a.rf_rdata_o[0]), 64'h0);
    chk("rst_rbusy", 64'(if_a.rf_rbusy_o), 64'h0);
    rstn_i = 1'b1;
    step();

    // Write x5 and mark x6 busy, then async reset mid-cycle
    if_a.rf_we_i[0]    = 1'b1;
    if_a.rf_waddr_i[0] = 5'd5;
    if_a.rf_wdata_i[0] = 32'hDEADBEEF;
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd6;
    step();
    idle_a();
    if_a.rf_raddr_i[1] = 5'd6;
    #1;
    chk("x5_written", 64'(if_a.rf_rdata_o[0]), 64'hDEADBEEF);
    chk("x6_busy", 64'(if_a.rf_rbusy_o[1]), 64'h1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("midrst_rdata", 64'(if_a.rf_rdata_o[0]), 64'h0);
    chk("midrst_rbusy", 64'(if_a.rf_rbusy_o[1]), 64'h0);
    step();
    rstn_i = 1'b1;
    step();

    // Two ports, two addresses in one cycle; x0 stays zero
    if_a.rf_we_i       = 2'b11;
    if_a.rf_waddr_i[0] = 5'd1;
    if_a.rf_wdata_i[0] = 32'h11111111;
    if_a.rf_waddr_i[1] = 5'd31;
    if_a.rf_wdata_i[1] = 32'hFFFF0000;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd1;
    if_a.rf_raddr_i[1] = 5'd31;
    #1;
    chk("x1_port0", 64'(if_a.rf_rdata_o[0]), 64'h11111111);
    chk("x31_port1", 64'(if_a.rf_rdata_o[1]), 64'hFFFF0000);
    if_a.rf_we_i[0]    = 1'b1;
    if_a.rf_waddr_i[0] = 5'd0;
    if_a.rf_wdata_i[0] = 32'h12345678;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd0;
    #1;
    chk("x0_zero", 64'(if_a.rf_rdata_o[0]), 64'h0);

    // Same-address conflict: port 1 wins
    if_a.rf_we_i       = 2'b11;
    if_a.rf_waddr_i[0] = 5'd7;
    if_a.rf_wdata_i[0] = 32'h0000AAAA;
    if_a.rf_waddr_i[1] = 5'd7;
    if_a.rf_wdata_i[1] = 32'h0000BBBB;
    step();
    idle_a();
    if_a.rf_raddr_i[1] = 5'd7;
    #1;
    chk("x7_conflict", 64'(if_a.rf_rdata_o[1]), 64'hBBBB);

    // Scoreboard set / clear-by-write / set-beats-write
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd3;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd3;
    #1;
    chk("x3_set", 64'(if_a.rf_rbusy_o[0]), 64'h1);
    if_a.rf_we_i[0]    = 1'b1;
    if_a.rf_waddr_i[0] = 5'd3;
    if_a.rf_wdata_i[0] = 32'h55;
    step();
    idle_a();
    #1;
    chk("x3_clr_busy", 64'(if_a.rf_rbusy_o[0]), 64'h0);
    chk("x3_clr_data", 64'(if_a.rf_rdata_o[0]), 64'h55);
    if_a.rf_we_i[0]    = 1'b1;
    if_a.rf_waddr_i[0] = 5'd3;
    if_a.rf_wdata_i[0] = 32'h66;
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd3;
    step();
    idle_a();
    #1;
    chk("x3_setwr_busy", 64'(if_a.rf_rbusy_o[0]), 64'h1);
    chk("x3_setwr_data", 64'(if_a.rf_rdata_o[0]), 64'h66);

    // Flush with x3, x4 busy
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd4;
    step();
    idle_a();
    if_a.rf_raddr_i[1] = 5'd4;
    #1;
    chk("pre_flush_busy", 64'(if_a.rf_rbusy_o), 64'h3);
    if_a.rf_flush_i = 1'b1;
    step();
    idle_a();
    #1;
    chk("post_flush_busy", 64'(if_a.rf_rbusy_o), 64'h0);

    // Flush beats a same-cycle set; same-cycle write data still commits
    if_a.rf_flush_i    = 1'b1;
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd10;
    if_a.rf_we_i[1]    = 1'b1;
    if_a.rf_waddr_i[1] = 5'd11;
    if_a.rf_wdata_i[1] = 32'h1234;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd10;
    if_a.rf_raddr_i[1] = 5'd11;
    #1;
    chk("flush_vs_set", 64'(if_a.rf_rbusy_o[0]), 64'h0);
    chk("flush_wr_data", 64'(if_a.rf_rdata_o[1]), 64'h1234);

    // Set to x0 is ignored
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd0;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd0;
    #1;
    chk("x0_never_busy", 64'(if_a.rf_rbusy_o[0]), 64'h0);

    // Forwarding behaviour on busy x9
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd9;
    step();
    idle_a();
    if_a.rf_raddr_i[0] = 5'd9;
    if_a.rf_we_i[0]    = 1'b1;
    if_a.rf_waddr_i[0] = 5'd9;
    if_a.rf_wdata_i[0] = 32'hCAFE;
    #1;
`ifdef BETA_RF_BYPASS_EN
    chk("x9_same_data", 64'(if_a.rf_rdata_o[0]), 64'hCAFE);
    chk("x9_same_busy", 64'(if_a.rf_rbusy_o[0]), 64'h0);
`else
    chk("x9_same_data", 64'(if_a.rf_rdata_o[0]), 64'h0);
    chk("x9_same_busy", 64'(if_a.rf_rbusy_o[0]), 64'h1);
`endif
    step();
    idle_a();
    #1;
    chk("x9_next_data", 64'(if_a.rf_rdata_o[0]), 64'hCAFE);
    chk("x9_next_busy", 64'(if_a.rf_rbusy_o[0]), 64'h0);

    // Forwarding with a two-port conflict and a same-cycle set on x12
    if_a.rf_raddr_i[1] = 5'd12;
    if_a.rf_we_i       = 2'b11;
    if_a.rf_waddr_i[0] = 5'd12;
    if_a.rf_wdata_i[0] = 32'h1;
    if_a.rf_waddr_i[1] = 5'd12;
    if_a.rf_wdata_i[1] = 32'h2;
    if_a.rf_set_busy_i = 1'b1;
    if_a.rf_set_addr_i = 5'd12;
    #1;
`ifdef BETA_RF_BYPASS_EN
    chk("x12_fwd_data", 64'(if_a.rf_rdata_o[1]), 64'h2);
    chk("x12_fwd_busy", 64'(if_a.rf_rbusy_o[1]), 64'h1);
`else
    chk("x12_fwd_data", 64'(if_a.rf_rdata_o[1]), 64'h0);
    chk("x12_fwd_busy", 64'(if_a.rf_rbusy_o[1]), 64'h0);
`endif
    step();
    idle_a();
    #1;
    chk("x12_next_data", 64'(if_a.rf_rdata_o[1]), 64'h2);
    chk("x12_next_busy", 64'(if_a.rf_rbusy_o[1]), 64'h1);

    // Sweep: 16 x 64-bit, alternate write ports, read each register on every read port
    for (int r = 0; r < 16; r++) begin
      if_b.rf_we_i                = '0;
      if_b.rf_we_i[r % 2]         = 1'b1;
      if_b.rf_waddr_i[r % 2]      = 4'(r);
      if_b.rf_wdata_i[r % 2]      = sweep_val(r);
      step();
    end
    if_b.rf_we_i = '0;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 4; p++) begin
        if_b.rf_raddr_i[p] = 4'(r);
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("sweep_x%0d_p%0d", r, p), if_b.rf_rdata_o[p],
            (r == 0) ? 64'h0 : sweep_val(r));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beta_regfile_mp.md
# beta_regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, the next generation of the core's register file. Supports a configurable number of registers, read ports and write ports, so it can serve both the single-issue and the dual-issue pipeline. Tracks outstanding writebacks per register so decode can stall on RAW hazards. Sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- DataWidth, 32, width of each register
- NumRegs, 32, number of architectural registers (power of two, ≥2); AddrWidth = $clog2(NumRegs), derived
- NumReadPorts, 2, number of read ports (≥1)
- NumWritePorts, 1, number of write ports (≥1)

- clk_i  input  1  clock, all state updates on rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- rf_raddr_i  input  [NumReadPorts-1:0][AddrWidth-1:0]  read addresses
- rf_rdata_o  output  [NumReadPorts-1:0][DataWidth-1:0]  read data
- rf_rbusy_o  output  [NumReadPorts-1:0]  1 = addressed register has a pending write
- rf_we_i  input  [NumWritePorts-1:0]  write enables
- rf_waddr_i  input  [NumWritePorts-1:0][AddrWidth-1:0]  write addresses
- rf_wdata_i  input  [NumWritePorts-1:0][DataWidth-1:0]  write data
- rf_set_busy_i  input  1  mark rf_set_addr_i busy (instruction issued)
- rf_set_addr_i  input  AddrWidth  register to mark busy
- rf_flush_i  input  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NumRegs x DataWidth registers plus NumRegs busy bits.
- Register 0 hardwired: always reads 0, never written, never busy (writes and sets to 0 ignored).
- Reads combinational: rf_rdata_o[p] = reg[rf_raddr_i[p]]; rf_rbusy_o[p] = busy[rf_raddr_i[p]].
- Write: on rising edge, for each port with rf_we_i=1 and nonzero address, reg[addr] <= wdata and busy[addr] <= 0.
- Write conflict (two ports, same address, same cycle): highest port index wins; busy still cleared.
- Busy set: rf_set_busy_i=1 and nonzero address -> busy[addr] <= 1 next edge.
- Set and write to same address same cycle: set wins (busy=1, data written) — new producer supersedes retiring one.
- rf_flush_i=1: all busy bits cleared next edge; takes priority over rf_set_busy_i; writes in the same cycle still commit data.
- Out-of-range addresses impossible by construction (NumRegs power of two).

## Timing
- Reset (rstn_i low, asynchronous): all registers 0, all busy bits 0; hence rf_rdata_o all 0, rf_rbusy_o all 0 while in reset and after release until written/set.
- Reset mid-operation: state cleared immediately regardless of clock; writes/sets in that cycle lost.
- Read latency: 0 cycles (combinational from address and state).
- Write latency: 1 cycle without bypass; data visible on read ports the cycle after rf_we_i.
- Busy set visible on rf_rbusy_o the cycle after rf_set_busy_i.
- No handshake; every write enable is accepted every cycle.

## Configuration
- BETA_RF_BYPASS_EN defined: write-to-read forwarding. If any write port writes nonzero address A this cycle and read port p addresses A, rf_rdata_o[p] = that write data (highest index port on conflict) and rf_rbusy_o[p] = 0 unless rf_set_busy_i also targets A this cycle (then 1). Read path combinational from rf_we_i/rf_waddr_i/rf_wdata_i.
- Not defined: reads reflect stored state only; same-cycle writes visible next cycle; busy output from stored bits only.

## Test plan
- Reset: drive rstn_i low mid-cycle after writing x5=0xDEADBEEF -> all rf_rdata_o=0, rf_rbusy_o=0 immediately.
- Write/read all ports: write x1=0x11111111 port0, x31=0xFFFF0000 port1 same cycle -> next cycle read ports show both; write x0=0x12345678 -> x0 reads 0.
- Conflict: both ports write x7 (0xAAAA, 0xBBBB) same cycle -> x7 reads 0xBBBB.
- Scoreboard: set busy x3 -> next cycle rf_rbusy_o=1 on port reading x3; write x3=0x55 -> next cycle busy=0, data 0x55; set+write x3 same cycle -> busy stays 1; flush with x3,x4 busy -> both 0 next cycle.
- Bypass (BETA_RF_BYPASS_EN): x9 busy, write x9=0xCAFE while port0 reads x9 -> same cycle rdata=0xCAFE, rbusy=0; without macro -> same cycle old value and rbusy=1, next cycle 0xCAFE/0.
- Parameter sweep: NumRegs=16, NumReadPorts=4, NumWritePorts=2, DataWidth=64 -> write/read each register through every port, all values match.
